// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-signalled event line: synchronises tog_in, turns each level
// change into an event, queues events as a saturating count and measures inter-event gaps.
module toggle_event_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned GAP_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [GAP_W-1:0] gap,
    output logic             gap_valid,
    output logic             stalled,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_MAX = {GAP_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   evt_det;
    logic                   pop;

    logic [CNT_W-1:0] pending_d;
    logic             overflow_d;

    state_t           state_q;
    state_t           state_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d;
    logic [GAP_W-1:0] gap_d;
    logic             gap_valid_d;
    logic             stalled_d;

    // Synchroniser chain and previous-level register for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level     = sync_q[SYNC_STAGES-1];
    assign evt_det   = level != prev_q;
    assign evt_valid = pending != '0;
    assign pop       = evt_valid & evt_ready;

    // Pending count: simultaneous event and pop cancel, so no overflow even at full count
    always_comb begin
        pending_d  = pending;
        overflow_d = overflow;
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (evt_det && !pop) begin
            if (pending == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending + CNT_W'(1);
            end
        end else if (pop && !evt_det) begin
            pending_d = pending - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

    // Gap-measurement FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            gap       <= '0;
            gap_valid <= 1'b0;
            stalled   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            gap       <= gap_d;
            gap_valid <= gap_valid_d;
            stalled   <= stalled_d;
        end
    end

    // Gap-measurement FSM: next state and registered-output next values
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        gap_d       = gap;
        gap_valid_d = 1'b0;
        stalled_d   = stalled;
        case (state_q)
            ST_IDLE: begin
                if (evt_det) begin
                    state_d   = ST_RUN;
                    gap_cnt_d = GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (evt_det) begin
                    gap_d       = gap_cnt_q;
                    gap_valid_d = 1'b1;
                    gap_cnt_d   = GAP_W'(1);
                end else if (gap_cnt_q == GAP_MAX) begin
                    // Full-scale gap elapsed with no event: line considered stalled
                    state_d   = ST_STALL;
                    stalled_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_STALL: begin
                if (evt_det) begin
                    state_d   = ST_RUN;
                    gap_cnt_d = GAP_W'(1);
                    stalled_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder (CNT_W=4, GAP_W=4 so saturation and stall are reachable).
module tb_toggle_event_decoder;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned GAP_W       = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tog_in = 1'b0;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             clr_ovf = 1'b0;
    logic [GAP_W-1:0] gap;
    logic             gap_valid;
    logic             stalled;
    logic             level;

    int vectors     = 0;
    int miscompares = 0;

    toggle_event_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .GAP_W      (GAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tog_in   (tog_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .gap      (gap),
        .gap_valid(gap_valid),
        .stalled  (stalled),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        tog_in    = 1'b0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pending", 32'(pending), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_gap", 32'(gap), 0);
        chk("rst_gap_valid", 32'(gap_valid), 0);
        chk("rst_stalled", 32'(stalled), 0);
        chk("rst_level", 32'(level), 0);

        // 1: single event latency and single pop
        tog_in = 1'b1;
        step();
        step();
        chk("t1_level", 32'(level), 1);
        chk("t1_pending_early", 32'(pending), 0);
        step();
        chk("t1_pending", 32'(pending), 1);
        chk("t1_evt_valid", 32'(evt_valid), 1);
        chk("t1_no_gap_valid", 32'(gap_valid), 0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("t1_pop_pending", 32'(pending), 0);
        chk("t1_pop_evt_valid", 32'(evt_valid), 0);

        // Reset released with tog_in high yields one event
        rst = 1'b1;
        step();
        chk("rh_pending_in_rst", 32'(pending), 0);
        rst = 1'b0;
        step();
        step();
        chk("rh_pending_early", 32'(pending), 0);
        step();
        chk("rh_pending", 32'(pending), 1);

        // 2: five toggles spaced 4 cycles, no pop, then drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tog_in = ~tog_in;
            step();
            step();
            step();
            chk($sformatf("t2_pending_%0d", i), 32'(pending), 32'(i + 1));
            chk($sformatf("t2_gap_valid_%0d", i), 32'(gap_valid), (i != 0) ? 32'd1 : 32'd0);
            if (i != 0) chk($sformatf("t2_gap_%0d", i), 32'(gap), 4);
            step();
            chk($sformatf("t2_gap_valid_off_%0d", i), 32'(gap_valid), 0);
        end
        evt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("t2_drain_%0d", k), 32'(pending), (k < 4) ? 32'(4 - k) : 32'd0);
        end
        evt_ready = 1'b0;
        chk("t2_evt_valid_low", 32'(evt_valid), 0);

        // 3: saturation, overflow, clear, edge+pop at max, set-wins-over-clear
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tog_in = ~tog_in;
            step();
            step();
        end
        chk("t3_pending_15", 32'(pending), 15);
        chk("t3_no_ovf_yet", 32'(overflow), 0);
        step();
        chk("t3_pending_hold", 32'(pending), 15);
        chk("t3_overflow", 32'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t3_ovf_cleared", 32'(overflow), 0);
        tog_in = ~tog_in;
        step();
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("t3_edge_pop_pending", 32'(pending), 15);
        chk("t3_edge_pop_no_ovf", 32'(overflow), 0);
        tog_in = ~tog_in;
        step();
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t3_set_wins", 32'(overflow), 1);
        step();
        chk("t3_sticky", 32'(overflow), 1);

        // 4: stall after 15 quiet cycles, recovery, then gap of 6
        do_reset();
        tog_in = ~tog_in;
        step();
        step();
        step();
        for (int k = 0; k < 14; k++) step();
        chk("t4_not_stalled_14", 32'(stalled), 0);
        step();
        chk("t4_stalled_15", 32'(stalled), 1);
        tog_in = ~tog_in;
        step();
        step();
        step();
        chk("t4_unstalled", 32'(stalled), 0);
        chk("t4_no_gap_valid", 32'(gap_valid), 0);
        chk("t4_gap_held", 32'(gap), 0);
        step();
        step();
        step();
        tog_in = ~tog_in;
        step();
        step();
        step();
        chk("t4_gap_valid", 32'(gap_valid), 1);
        chk("t4_gap_6", 32'(gap), 6);

        // 5: back-to-back events
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) tog_in = ~tog_in;
            step();
            if (i >= 2 && i <= 5) chk($sformatf("t5_pending_%0d", i), 32'(pending), 32'(i - 1));
            if (i == 2) chk("t5_first_no_gv", 32'(gap_valid), 0);
            if (i >= 3 && i <= 5) begin
                chk($sformatf("t5_gap_valid_%0d", i), 32'(gap_valid), 1);
                chk($sformatf("t5_gap_%0d", i), 32'(gap), 1);
            end
        end
        chk("t5_gap_valid_end", 32'(gap_valid), 0);

        // 6: reset mid-operation discards queued events and returns to IDLE
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("t6_pending_3", 32'(pending), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_pending", 32'(pending), 0);
        chk("t6_evt_valid", 32'(evt_valid), 0);
        chk("t6_gap", 32'(gap), 0);
        chk("t6_overflow", 32'(overflow), 0);
        tog_in = ~tog_in;
        step();
        step();
        step();
        chk("t6_idle_pending", 32'(pending), 1);
        chk("t6_idle_no_gv", 32'(gap_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
